io_harness: RTL and testbench

IO_HARNESS -- requirements
Module: io_harness

---
 rtl/io_harness.sv | 187 ++++++++++++++++++
 tb/tb_io_harness.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_harness.sv
// io_harness: run-control FSM, watchdog and buffered I/O between a CPU and a host.
// The CPU writes words into an output FIFO that the host drains through a
// show-ahead valid/ready port. The host fills an input FIFO that the CPU
// reads one word per request.
// Handshake rule on both host ports: a word moves on a rising clock edge
// exactly when valid and ready are both high in that cycle. Valid does not
// depend on ready.
module io_harness #(
  parameter int DATA_W    = 64,
  parameter int OUT_DEPTH = 8,
  parameter int IN_DEPTH  = 8,
  parameter int TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpu_halt,
  input  logic              cpu_out_signal,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic              cpu_in_req,
  output logic              cpu_in_valid,
  output logic [DATA_W-1:0] cpu_in_data,
  output logic              cpu_run,
  output logic              cpu_stall,
  input  logic              host_in_valid,
  input  logic [DATA_W-1:0] host_in_data,
  output logic              host_in_ready,
  output logic              host_out_valid,
  output logic [DATA_W-1:0] host_out_data,
  input  logic              host_out_ready,
  output logic [1:0]        state,
  output logic [31:0]       cycle_count,
  output logic              out_overflow
);

  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam logic [OAW:0] OUT_ONE = 1;
  localparam logic [IAW:0] IN_ONE  = 1;
  // Value of cycle_count during the last RUN cycle the watchdog allows.
  localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0] count_q;
  logic        ovf_q;
  logic        pend_q;
  logic        in_valid_q;
  logic [DATA_W-1:0] in_data_q;

  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  logic [OAW:0]      out_wr_q, out_rd_q;
  logic [DATA_W-1:0] in_mem [IN_DEPTH];
  logic [IAW:0]      in_wr_q, in_rd_q;

  logic in_run, enter_run, wd_hit;
  logic out_empty, out_full, out_push_req, out_push, out_pop;
  logic in_empty, in_full, in_push, want_new, deliver;

  assign in_run    = (state_q == S_RUN);
  assign enter_run = !in_run && (state_d == S_RUN);
  assign wd_hit    = (TIMEOUT != 0) && (count_q == TO_LAST);

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[OAW] != out_rd_q[OAW]) &&
                     (out_wr_q[OAW-1:0] == out_rd_q[OAW-1:0]);
  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[IAW] != in_rd_q[IAW]) &&
                     (in_wr_q[IAW-1:0] == in_rd_q[IAW-1:0]);

  assign out_pop      = !out_empty && host_out_ready;
  assign out_push_req = in_run && cpu_out_signal;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign out_push     = out_push_req && (!out_full || out_pop);

  assign in_push  = host_in_valid && !in_full;
  // A new request is taken only when none is pending or being delivered.
  assign want_new = in_run && cpu_in_req && !pend_q && !in_valid_q;
  // Emptiness is the registered view, so a word pushed this cycle is not
  // forwarded until the next edge.
  assign deliver  = in_run && (pend_q || want_new) && !in_empty;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a halt takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_RUN;
      S_RUN: begin
        if (cpu_halt)    state_d = S_HALTED;
        else if (wd_hit) state_d = S_TIMEOUT;
      end
      S_HALTED,
      S_TIMEOUT: if (start) state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs: CPU enable and hold request.
  always_comb begin
    cpu_run   = in_run;
    cpu_stall = in_run && (out_full || pend_q);
  end

  // Run cycle counter (saturating) and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (enter_run)                      count_q <= '0;
      else if (in_run && count_q != '1)   count_q <= count_q + 32'd1;
      if (enter_run)                                   ovf_q <= 1'b0;
      else if (out_push_req && out_full && !out_pop)   ovf_q <= 1'b1;
    end
  end

  // Output FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr_q <= '0;
      out_rd_q <= '0;
    end else begin
      if (out_push) out_wr_q <= out_wr_q + OUT_ONE;
      if (out_pop)  out_rd_q <= out_rd_q + OUT_ONE;
    end
  end

  // Output FIFO storage; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_q[OAW-1:0]] <= cpu_out_data;
  end

  // Input FIFO pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_q <= '0;
      in_rd_q <= '0;
    end else begin
      if (in_push) in_wr_q <= in_wr_q + IN_ONE;
      if (deliver) in_rd_q <= in_rd_q + IN_ONE;
    end
  end

  // Input FIFO storage.
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_q[IAW-1:0]] <= host_in_data;
  end

  // CPU read path: pending flag and the one-cycle delivery register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q     <= 1'b0;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
    end else begin
      if (enter_run)     pend_q <= 1'b0;
      else if (deliver)  pend_q <= 1'b0;
      else if (want_new) pend_q <= 1'b1;
      in_valid_q <= deliver;
      if (deliver) in_data_q <= in_mem[in_rd_q[IAW-1:0]];
    end
  end

  assign state          = state_q;
  assign cycle_count    = count_q;
  assign out_overflow   = ovf_q;
  assign cpu_in_valid   = in_valid_q;
  assign cpu_in_data    = in_data_q;
  assign host_in_ready  = !in_full;
  assign host_out_valid = !out_empty;
  assign host_out_data  = out_mem[out_rd_q[OAW-1:0]];

endmodule

// File: tb/tb_io_harness.sv
// Testbench for io_harness: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_io_harness;

  localparam int DATA_W    = 64;
  localparam int OUT_DEPTH = 8;
  localparam int IN_DEPTH  = 8;
  localparam int TIMEOUT   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0, cpu_halt = 1'b0;
  logic              cpu_out_signal = 1'b0;
  logic [DATA_W-1:0] cpu_out_data = '0;
  logic              cpu_in_req = 1'b0;
  logic              cpu_in_valid;
  logic [DATA_W-1:0] cpu_in_data;
  logic              cpu_run, cpu_stall;
  logic              host_in_valid = 1'b0;
  logic [DATA_W-1:0] host_in_data = '0;
  logic              host_in_ready;
  logic              host_out_valid;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_ready = 1'b0;
  logic [1:0]        state;
  logic [31:0]       cycle_count;
  logic              out_overflow;

  io_harness #(.DATA_W(DATA_W), .OUT_DEPTH(OUT_DEPTH), .IN_DEPTH(IN_DEPTH),
               .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_halt(cpu_halt),
    .cpu_out_signal(cpu_out_signal), .cpu_out_data(cpu_out_data),
    .cpu_in_req(cpu_in_req), .cpu_in_valid(cpu_in_valid), .cpu_in_data(cpu_in_data),
    .cpu_run(cpu_run), .cpu_stall(cpu_stall),
    .host_in_valid(host_in_valid), .host_in_data(host_in_data),
    .host_in_ready(host_in_ready), .host_out_valid(host_out_valid),
    .host_out_data(host_out_data), .host_out_ready(host_out_ready),
    .state(state), .cycle_count(cycle_count), .out_overflow(out_overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_q[$];   // words the host should see, in order
  logic [DATA_W-1:0] in_q[$];    // words waiting for the CPU
  int                m_state;
  logic [31:0]       m_cnt;
  bit                m_ovf, m_pend, m_iv;
  logic [DATA_W-1:0] m_id;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    in_q.delete();
    m_state = 0; m_cnt = 0; m_ovf = 0; m_pend = 0; m_iv = 0; m_id = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit run, enter, pop_o, take_req, dlv;
    int out_n, in_n, nxt;
    run   = (m_state == 1);
    out_n = exp_q.size();
    in_n  = in_q.size();
    nxt   = m_state;
    if (run) begin
      if (cpu_halt) nxt = 2;
      else if (m_cnt == 32'(TIMEOUT - 1)) nxt = 3;
    end else if (start) nxt = 1;
    enter = !run && (nxt == 1);

    pop_o = (out_n > 0) && host_out_ready;
    if (pop_o) void'(exp_q.pop_front());
    if (run && cpu_out_signal) begin
      if (out_n == OUT_DEPTH && !pop_o) m_ovf = 1;
      else exp_q.push_back(cpu_out_data);
    end
    if (enter) m_ovf = 0;

    take_req = run && cpu_in_req && !m_pend && !m_iv;
    dlv = run && (m_pend || take_req) && (in_n > 0);
    if (dlv) m_id = in_q.pop_front();
    m_iv = dlv;
    if (host_in_valid && in_n < IN_DEPTH) in_q.push_back(host_in_data);
    if (enter || dlv) m_pend = 0;
    else if (take_req) m_pend = 1;

    if (enter) m_cnt = 0;
    else if (run && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check("state", 64'(state), 64'(m_state));
    check("cycle_count", 64'(cycle_count), 64'(m_cnt));
    check("out_overflow", 64'(out_overflow), 64'(m_ovf));
    check("cpu_run", 64'(cpu_run), 64'(m_state == 1));
    check("cpu_stall", 64'(cpu_stall),
          64'((m_state == 1) && (exp_q.size() == OUT_DEPTH || m_pend)));
    check("host_out_valid", 64'(host_out_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("host_out_data", host_out_data, exp_q[0]);
    check("host_in_ready", 64'(host_in_ready), 64'(in_q.size() < IN_DEPTH));
    check("cpu_in_valid", 64'(cpu_in_valid), 64'(m_iv));
    check("cpu_in_data", cpu_in_data, m_id);
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    start = 0; cpu_halt = 0; cpu_out_signal = 0; cpu_out_data = '0;
    cpu_in_req = 0; host_in_valid = 0; host_in_data = '0; host_out_ready = 0;
  endtask

  // Asynchronous reset pulse, asserted and released away from rising edges.
  task automatic do_reset();
    clear_inputs();
    #2 reset = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic begin_run();
    start = 1; tick(); start = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_state", 64'(state), 64'd0);
    check("rst_host_in_ready", 64'(host_in_ready), 64'd1);
    check("rst_cpu_in_data", cpu_in_data, 64'd0);

    // Two output words seen by the host in order.
    begin_run();
    check("start_state", 64'(state), 64'd1);
    host_out_ready = 1;
    cpu_out_signal = 1; cpu_out_data = 5; tick();
    check("out_first", host_out_data, 64'd5);
    cpu_out_data = 7; tick();
    check("out_second", host_out_data, 64'd7);
    cpu_out_signal = 0; tick();
    check("out_drained", 64'(host_out_valid), 64'd0);

    // Input word ready before the request.
    do_reset(); begin_run();
    host_in_valid = 1; host_in_data = 64'h11; tick(); host_in_valid = 0;
    cpu_in_req = 1; tick(); cpu_in_req = 0;
    check("in_valid", 64'(cpu_in_valid), 64'd1);
    check("in_data", cpu_in_data, 64'h11);
    tick();
    check("in_valid_pulse", 64'(cpu_in_valid), 64'd0);
    check("in_data_hold", cpu_in_data, 64'h11);

    // Request with an empty FIFO stalls until the host supplies a word.
    do_reset(); begin_run();
    cpu_in_req = 1; tick(); cpu_in_req = 0;
    check("pend_stall", 64'(cpu_stall), 64'd1);
    host_in_valid = 1; host_in_data = 64'h22; tick(); host_in_valid = 0;
    check("no_bypass", 64'(cpu_in_valid), 64'd0);
    tick();
    check("pend_valid", 64'(cpu_in_valid), 64'd1);
    check("pend_data", cpu_in_data, 64'h22);
    check("pend_unstall", 64'(cpu_stall), 64'd0);

    // Output overflow: nine strobes into an eight-entry FIFO.
    do_reset(); begin_run();
    for (int i = 1; i <= 9; i++) begin
      cpu_out_signal = 1; cpu_out_data = 64'(i); tick();
      if (i == 8) begin
        check("full_stall", 64'(cpu_stall), 64'd1);
        check("full_no_ovf", 64'(out_overflow), 64'd0);
      end
    end
    cpu_out_signal = 0;
    check("ovf_set", 64'(out_overflow), 64'd1);
    cpu_halt = 1; tick(); cpu_halt = 0;
    check("halt_state", 64'(state), 64'd2);
    host_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_word", host_out_data, 64'(i));
      tick();
    end
    check("drain_empty", 64'(host_out_valid), 64'd0);
    host_out_ready = 0;

    // Watchdog, then halt colliding with the watchdog.
    do_reset(); begin_run();
    for (int i = 0; i < 15; i++) tick();
    check("wd_before", 64'(state), 64'd1);
    tick();
    check("wd_state", 64'(state), 64'd3);
    check("wd_count", 64'(cycle_count), 64'd16);
    begin_run();
    check("restart_count", 64'(cycle_count), 64'd0);
    for (int i = 0; i < 15; i++) tick();
    cpu_halt = 1; tick(); cpu_halt = 0;
    check("halt_wins", 64'(state), 64'd2);
    check("halt_count", 64'(cycle_count), 64'd16);

    // Reset in the middle of a run with both FIFOs holding data.
    do_reset();
    host_in_valid = 1;
    for (int i = 0; i < IN_DEPTH; i++) begin host_in_data = 64'(i + 100); tick(); end
    host_in_valid = 0;
    check("in_full", 64'(host_in_ready), 64'd0);
    begin_run();
    cpu_out_signal = 1; cpu_out_data = 64'hAB; tick(); cpu_out_signal = 0;
    check("pre_rst_out", 64'(host_out_valid), 64'd1);
    do_reset();
    check("abort_state", 64'(state), 64'd0);
    check("abort_out_valid", 64'(host_out_valid), 64'd0);
    check("abort_in_ready", 64'(host_in_ready), 64'd1);
    check("abort_run", 64'(cpu_run), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      start          = ($urandom_range(0, 11) == 0);
      cpu_halt       = ($urandom_range(0, 29) == 0);
      cpu_out_signal = $urandom_range(0, 1) == 1;
      cpu_out_data   = {$urandom, $urandom};
      cpu_in_req     = ($urandom_range(0, 3) == 0);
      host_in_valid  = ($urandom_range(0, 2) == 0);
      host_in_data   = {$urandom, $urandom};
      host_out_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                            : ($urandom_range(0, 5) == 0);
      tick();
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
